// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Definitions shared by the bit-serial adder files: the controller state
//   encoding, the default operand width and a counter-width helper.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  // Code 2'd3 is unused; the controller sends it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Smallest r with 2**r >= v, usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fulladder_ha.sv
// fulladder_ha
//   One-bit full adder made of two half-adder cells and an OR gate.
//   a, b : addend bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module fulladder_ha (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s1, c1, c2;

  halfadder u_ha1 (.a(a),  .b(b),   .s(s1), .c(c1));
  halfadder u_ha2 (.a(s1), .b(cin), .s(s),  .c(c2));

  // c1 and c2 can never be high together, so OR is the full carry.
  assign cout = c1 | c2;
endmodule

// File: rtl/halfadder.sv
// halfadder
//   One-bit half adder cell.
//   a, b : addend bits
//   s    : sum bit (a ^ b)
//   c    : carry bit (a & b)
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder. Operands are captured on an accepted start,
//   added LSB-first one bit per clock through a single full adder with a
//   registered carry, and the result is published with a one-cycle done.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request strobe, only looked at in IDLE
//   a, b  : operands, captured on the accepted start
//   busy  : high while not IDLE
//   done  : one-cycle pulse when sum/cout update
//   sum   : registered a+b mod 2**WIDTH, held until next completion
//   cout  : registered carry-out, held until next completion
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int                CNT_W    = clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, ss;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             sbit, fa_cout;
  logic             last_bit;

  assign last_bit = (cnt == CNT_LAST);

  fulladder_ha u_fa (
    .a   (sa[0]),
    .b   (sb[0]),
    .cin (carry),
    .s   (sbit),
    .cout(fa_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = start    ? ST_RUN  : ST_IDLE;
      ST_RUN:  state_nxt = last_bit ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Shift registers, carry, bit counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      ss    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        sa    <= a;
        sb    <= b;
        carry <= 1'b0;
        cnt   <= '0;
      end
    end else if (state == ST_RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      ss    <= {sbit, ss[WIDTH-1:1]};
      carry <= fa_cout;
      cnt   <= cnt + 1'b1;
      // On the last bit the result is published straight from the shift
      // path so this cycle's sum bit is included.
      if (last_bit) begin
        sum  <= {sbit, ss[WIDTH-1:1]};
        cout <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, busy, done, cout;
  logic [7:0] a, b, sum;
  logic       start4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one 8-bit addition from IDLE and wait for done. Operands are
  // scrambled while in flight. lat counts cycles from the accepting cycle
  // (1 = cycle after accept edge) up to the done cycle; -1 on timeout.
  // Returns during the DONE cycle.
  task automatic do_add(input logic [7:0] xa, input logic [7:0] xb,
                        output int lat, output logic [7:0] s, output logic c);
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    a = 8'($urandom); b = 8'($urandom);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      a = 8'($urandom); b = 8'($urandom);
    end
    if (!done) lat = -1;
    s = sum; c = cout;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++; $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
    end
    checks++;
    if ({busy4, done4, sum4, cout4} !== 7'd0) begin
      errors++; $display("FAIL reset4: got busy=%b done=%b sum=%h cout=%b want all 0", busy4, done4, sum4, cout4);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] va[4] = '{8'h00, 8'hFF, 8'hA5, 8'hFF};
    logic [7:0] vb[4] = '{8'h00, 8'h01, 8'h5A, 8'hFF};
    logic [8:0] exp;
    logic [7:0] s; logic c; int lat;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b0, va[i]} + {1'b0, vb[i]};
      do_add(va[i], vb[i], lat, s, c);
      checks++;
      if (lat != 9) begin
        errors++; $display("FAIL dir_latency[%0d]: got %0d want 9", i, lat);
      end
      checks++;
      if ({c, s} !== exp) begin
        errors++; $display("FAIL dir_result[%0d]: got cout=%b sum=%h want cout=%b sum=%h", i, c, s, exp[8], exp[7:0]);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL dir_after_done[%0d]: got busy=%b done=%b want 0 0", i, busy, done);
      end
      // Result must persist while idle before the next operation.
      repeat (3) @(negedge clk);
      checks++;
      if (sum !== exp[7:0] || cout !== exp[8]) begin
        errors++; $display("FAIL dir_hold[%0d]: got sum=%h cout=%b want sum=%h cout=%b", i, sum, cout, exp[7:0], exp[8]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] xa, xb, s; logic c; logic [8:0] exp; int lat;
    for (int i = 0; i < 16; i++) begin
      xa = 8'($urandom); xb = 8'($urandom);
      exp = {1'b0, xa} + {1'b0, xb};
      do_add(xa, xb, lat, s, c);
      checks++;
      if (lat != 9 || {c, s} !== exp) begin
        errors++; $display("FAIL rand[%0d] %h+%h: got lat=%0d cout=%b sum=%h want lat=9 cout=%b sum=%h",
                           i, xa, xb, lat, c, s, exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0, done_cyc = -1;
    logic bad_busy = 1'b0;
    for (int cyc = 0; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (done) begin ndone++; done_cyc = cyc; end
      if (cyc >= 11 && busy) bad_busy = 1'b1;
      if (cyc == 0)                  begin a = 8'h10; b = 8'h20; start = 1'b1; end
      else if (cyc == 3 || cyc == 9) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
      else                           start = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (ndone != 1 || done_cyc != 9) begin
      errors++; $display("FAIL ignore_done: got %0d pulses last at cycle %0d want 1 at cycle 9", ndone, done_cyc);
    end
    checks++;
    if (sum !== 8'h30 || cout !== 1'b0) begin
      errors++; $display("FAIL ignore_sum: got sum=%h cout=%b want 30 0", sum, cout);
    end
    checks++;
    if (bad_busy) begin
      errors++; $display("FAIL ignore_requeue: got busy=1 after completion want 0");
    end
  endtask

  task automatic test_abort();
    int ndone = 0; int lat;
    logic [7:0] s; logic c;
    for (int cyc = 0; cyc <= 15; cyc++) begin
      @(negedge clk);
      if (done) ndone++;
      if (cyc == 5) begin
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
          errors++; $display("FAIL abort_outputs: got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
        end
      end
      start = (cyc == 0);
      if (cyc == 0) begin a = 8'h7F; b = 8'h01; end
      rst = (cyc == 4);
    end
    checks++;
    if (ndone != 0) begin
      errors++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone);
    end
    do_add(8'h7F, 8'h01, lat, s, c);
    checks++;
    if (lat != 9 || s !== 8'h80 || c !== 1'b0) begin
      errors++; $display("FAIL abort_restart: got lat=%0d sum=%h cout=%b want 9 80 0", lat, s, c);
    end
    // Reset while in DONE: pulse ends and the result registers clear.
    do_add(8'h12, 8'h34, lat, s, c);
    checks++;
    if (s !== 8'h46) begin
      errors++; $display("FAIL done_rst_pre: got sum=%h want 46", s);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++; $display("FAIL done_rst: got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ea, eb; logic [8:0] exp;
    int prev = -1, ndone = 0;
    @(negedge clk);
    ea = 8'($urandom); eb = 8'($urandom);
    a = ea; b = eb; start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        exp = {1'b0, ea} + {1'b0, eb};
        checks++;
        if ((prev < 0 && cyc != 9) || (prev >= 0 && cyc - prev != 10)) begin
          errors++; $display("FAIL b2b_period: done at cycle %0d prev %0d want first 9 then every 10", cyc, prev);
        end
        checks++;
        if ({cout, sum} !== exp) begin
          errors++; $display("FAIL b2b_result: got cout=%b sum=%h want cout=%b sum=%h", cout, sum, exp[8], exp[7:0]);
        end
        prev = cyc; ndone++;
        // New operands take effect at the next accept from IDLE.
        ea = 8'($urandom); eb = 8'($urandom);
        a = ea; b = eb;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 4) begin
      errors++; $display("FAIL b2b_count: got %0d pulses want 4", ndone);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_width4();
    logic [3:0] va[4] = '{4'hF, 4'h0, 4'h9, 4'h7};
    logic [3:0] vb[4] = '{4'h1, 4'h0, 4'h8, 4'h3};
    logic [4:0] exp; int lat;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b0, va[i]} + {1'b0, vb[i]};
      @(negedge clk);
      a4 = va[i]; b4 = vb[i]; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); lat = 1;
      while (!done4 && lat < 20) begin @(negedge clk); lat++; end
      checks++;
      if (!done4 || lat != 5) begin
        errors++; $display("FAIL w4_latency[%0d]: got %0d want 5", i, done4 ? lat : -1);
      end
      checks++;
      if ({cout4, sum4} !== exp) begin
        errors++; $display("FAIL w4_result[%0d]: got cout=%b sum=%h want cout=%b sum=%h", i, cout4, sum4, exp[4], exp[3:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_width4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
